// File: rtl/ir_pkg.sv
// Shared types and constants for the IR transmit scheduler.
package ir_pkg;

  // Frame segment widths of the NEC-style transmitter
  localparam int unsigned IR_W35 = 35;
  localparam int unsigned IR_W32 = 32;

  // Default timing at the 100 MHz system clock
  localparam int unsigned IR_GAP_CYC_DEF     = 4000000;   // 40 ms inter-frame gap
  localparam int unsigned IR_TIMEOUT_CYC_DEF = 20000000;  // 200 ms hung-transmitter limit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } ir_state_e;

  // Larger of two cycle counts; sizes the shared gap/timeout counter
  function automatic int unsigned ir_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_prio_arb.sv
// Lowest-index-first one-hot request picker (purely combinational).
module ir_prio_arb #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_any
);

  // Walk from the top index down so the lowest set bit has the final say
  always_comb begin
    o_gnt = '0;
    o_any = |i_req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_tx_scheduler.sv
// IR command scheduler: arbitrates requesters onto one NEC-style transmitter,
// sends each accepted command REPEATS times with a GAP_CYC idle gap after
// every frame, and aborts a frame when tx_done does not return in time.
// Optional build macro IR_TX_DEDUP_EN: a command identical to the last
// completed frame is acknowledged (gnt) but not transmitted again.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and grant happen here
// SEND  | one-cycle tx_start pulse for the latched frame
// WAIT  | waiting for tx_done, bounded by TIMEOUT_CYC
// GAP   | mandatory idle gap, then repeat or return to IDLE
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int GAP_CYC     = IR_GAP_CYC_DEF,
  parameter int REPEATS     = 2,
  parameter int TIMEOUT_CYC = IR_TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*IR_W35-1:0]   req_data35,
  input  logic [NREQ*IR_W32-1:0]   req_data32,
  output logic [NREQ-1:0]          gnt,
  output logic                     tx_start,
  output logic [IR_W35-1:0]        tx_data35,
  output logic [IR_W32-1:0]        tx_data32,
  input  logic                     tx_done,
  output logic                     tx_abort,
  output logic                     busy,
  output logic                     frame_sent,
  output logic                     err_timeout
);

  // Gap and WAIT never overlap, so one counter serves both
  localparam int CW = $clog2(ir_max(GAP_CYC, TIMEOUT_CYC) + 1);
  localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;

  ir_state_e          r_state;
  ir_state_e          w_next;
  logic [CW-1:0]      r_cnt;
  logic [RW-1:0]      r_rep;
  logic [NREQ-1:0]    r_gnt;
  logic [IR_W35-1:0]  r_d35;
  logic [IR_W32-1:0]  r_d32;
  logic               r_err;

  logic [NREQ-1:0]    w_win;
  logic               w_any;
  logic [IR_W35-1:0]  w_win35;
  logic [IR_W32-1:0]  w_win32;
  logic               w_accept;
  logic               w_dup;
  logic               w_launch;
  logic               w_expire;
  logic               w_timeout;
  logic               w_gap_end;

  ir_prio_arb #(.NREQ(NREQ)) u_arb (
    .i_req (req),
    .o_gnt (w_win),
    .o_any (w_any)
  );

  // Route the winning source's frame segments
  always_comb begin
    w_win35 = '0;
    w_win32 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win[k]) begin
        w_win35 = req_data35[k*IR_W35 +: IR_W35];
        w_win32 = req_data32[k*IR_W32 +: IR_W32];
      end
    end
  end

`ifdef IR_TX_DEDUP_EN
  logic [IR_W35-1:0] r_last35;
  logic [IR_W32-1:0] r_last32;

  // Remember the last frame the transmitter actually finished (aborts do not count)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last35 <= '0;
      r_last32 <= '0;
    end else if (r_state == WAIT && tx_done) begin
      r_last35 <= r_d35;
      r_last32 <= r_d32;
    end
  end

  assign w_dup = (w_win35 == r_last35) && (w_win32 == r_last32);
`else
  assign w_dup = 1'b0;
`endif

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_launch  = w_accept && !w_dup;
  assign w_expire  = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT_CYC - 1));
  // A tx_done landing on the expiry cycle wins over the timeout
  assign w_timeout = w_expire && !tx_done;
  assign w_gap_end = (r_state == GAP) && (r_cnt == CW'(GAP_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_launch) w_next = SEND;
      SEND: w_next = WAIT;
      WAIT: if (tx_done || w_expire) w_next = GAP;
      GAP:  if (w_gap_end) w_next = (r_rep != '0) ? SEND : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pulse outputs; held off while rst is asserted so a mid-frame reset emits nothing
  always_comb begin
    tx_start   = 1'b0;
    tx_abort   = 1'b0;
    frame_sent = 1'b0;
    busy       = (r_state != IDLE);
    if (!rst) begin
      tx_start   = (r_state == SEND);
      tx_abort   = w_timeout;
      frame_sent = (r_state == WAIT) && tx_done;
    end
  end

  // Shared gap/timeout counter: runs in WAIT and GAP, cleared on every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        WAIT:    r_cnt <= (tx_done || w_expire) ? '0 : r_cnt + CW'(1);
        GAP:     r_cnt <= w_gap_end ? '0 : r_cnt + CW'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  // Remaining repeats: loaded on launch, spent at each gap end, dropped on timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep <= '0;
    end else if (w_launch) begin
      r_rep <= RW'(REPEATS - 1);
    end else if (w_timeout) begin
      r_rep <= '0;
    end else if (w_gap_end && r_rep != '0) begin
      r_rep <= r_rep - RW'(1);
    end
  end

  // Grant pulse and frame latch on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= '0;
      r_d35 <= '0;
      r_d32 <= '0;
    end else begin
      r_gnt <= w_accept ? w_win : '0;
      if (w_launch) begin
        r_d35 <= w_win35;
        r_d32 <= w_win32;
      end
    end
  end

  // Sticky hung-transmitter flag
  always_ff @(posedge clk) begin
    if (rst)            r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  assign gnt         = r_gnt;
  assign tx_data35   = r_d35;
  assign tx_data32   = r_d32;
  assign err_timeout = r_err;

endmodule
